deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_pkg.sv | 19 +
 rtl/deserializer.sv | 117 +++++++++++
 tb/tb_deserializer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared constants and state encoding for the serial-to-parallel frame deserializer.
package deserializer_pkg;

  localparam int PIO_SIZE_DEF = 256;
  localparam int SIO_SIZE_DEF = 16;
  localparam int BEATS        = PIO_SIZE_DEF / SIO_SIZE_DEF;
  localparam int CNT_W        = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  function automatic int calc_beats(input int pio, input int sio);
    return pio / sio;
  endfunction

endpackage

// File: rtl/deserializer.sv
// Collects SIO_SIZE-bit beats into one PIO_SIZE-bit frame (beat 0 in the LSBs) and
// holds it with output_valid until the consumer takes it; frame_start mid-frame resyncs.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int PIO_SIZE  = 256,
  parameter int SIO_SIZE  = 16,
  parameter int WORD_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SIO_SIZE-1:0] serial_in,
  input  logic                input_valid,
  input  logic                frame_start,
  output logic                input_ready,
  output logic [PIO_SIZE-1:0] parallel_out,
  output logic                output_valid,
  input  logic                output_ready,
  output logic                frame_error
);

  localparam int L_BEATS = calc_beats(PIO_SIZE, SIO_SIZE);
  localparam int L_CNT_W = $clog2(L_BEATS + 1);
  localparam logic [L_CNT_W-1:0] L_BEATS_C = L_CNT_W'(L_BEATS);
  localparam logic [L_CNT_W-1:0] L_ONE     = L_CNT_W'(1);

  if ((PIO_SIZE % WORD_SIZE) != 0 || (WORD_SIZE % SIO_SIZE) != 0) begin : g_bad_cfg
    $error("deserializer: PIO_SIZE must be a multiple of WORD_SIZE, WORD_SIZE of SIO_SIZE");
  end

  state_e               r_state;
  state_e               w_next;
  logic [L_CNT_W-1:0]   r_cnt;
  logic [L_CNT_W-1:0]   w_cnt_nxt;
  logic [L_CNT_W-1:0]   w_wr_idx;
  logic                 w_wr_en;
  logic                 w_err;
  logic                 w_accept;
  logic [PIO_SIZE-1:0]  r_data;
  logic                 r_out_valid;
  logic                 r_err;

  assign input_ready  = (r_state != ST_HOLD);
  assign w_accept     = input_valid && input_ready;
  assign parallel_out = r_data;
  assign output_valid = r_out_valid;
  assign frame_error  = r_err;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_cnt;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Beats arriving without a frame_start while idle are simply dropped.
        if (w_accept && frame_start) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = '0;
          w_cnt_nxt = L_ONE;
          w_next    = (L_ONE == L_BEATS_C) ? ST_HOLD : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (frame_start) begin
            w_err     = 1'b1;
            w_wr_idx  = '0;
            w_cnt_nxt = L_ONE;
          end else begin
            w_cnt_nxt = r_cnt + L_ONE;
            if (w_cnt_nxt == L_BEATS_C) w_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (output_ready) begin
          w_next    = ST_IDLE;
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_next    = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_next == ST_HOLD);
      r_err       <= w_err;
    end
  end

  // Slices are never cleared between frames; only the written slice changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else begin
      for (int k = 0; k < L_BEATS; k++) begin
        if (w_wr_en && (w_wr_idx == L_CNT_W'(k)))
          r_data[k*SIO_SIZE +: SIO_SIZE] <= serial_in;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus a randomized stream
// compared against a queue-based frame model.
module tb_deserializer;

  localparam int PIO = 256;
  localparam int SIO = 16;
  localparam int NB  = PIO / SIO;

  logic           clk = 1'b0;
  logic           reset;
  logic [SIO-1:0] serial_in;
  logic           input_valid;
  logic           frame_start;
  logic           input_ready;
  logic [PIO-1:0] parallel_out;
  logic           output_valid;
  logic           output_ready;
  logic           frame_error;

  int checks   = 0;
  int failures = 0;

  deserializer #(.PIO_SIZE(PIO), .SIO_SIZE(SIO), .WORD_SIZE(32)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .input_valid(input_valid),
    .frame_start(frame_start), .input_ready(input_ready), .parallel_out(parallel_out),
    .output_valid(output_valid), .output_ready(output_ready), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Offer one beat for one cycle; returns at the following negedge.
  task automatic beat(input logic [SIO-1:0] d, input logic s);
    serial_in = d; frame_start = s; input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0; frame_start = 1'b0;
  endtask

  function automatic logic [PIO-1:0] pack(input logic [SIO-1:0] b [NB]);
    logic [PIO-1:0] f = '0;
    for (int k = 0; k < NB; k++) f[k*SIO +: SIO] = b[k];
    return f;
  endfunction

  task automatic release_frame();
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    checks++;
    if (output_valid !== 1'b0) begin
      failures++; $display("FAIL release_ov: got %b want 0", output_valid);
    end
    checks++;
    if (input_ready !== 1'b1) begin
      failures++; $display("FAIL release_ready: got %b want 1", input_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; input_valid = 1'b1; frame_start = 1'b1; serial_in = 16'hFFFF; output_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (output_valid !== 1'b0 || frame_error !== 1'b0) begin
      failures++; $display("FAIL reset_flags: ov=%b fe=%b want 0 0", output_valid, frame_error);
    end
    checks++;
    if (parallel_out !== '0) begin
      failures++; $display("FAIL reset_data: got %h want 0", parallel_out);
    end
    reset = 1'b0; input_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    checks++;
    if (input_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", input_ready);
    end
  endtask

  task automatic test_back_to_back(input bit gaps);
    logic [SIO-1:0] b [NB];
    logic [PIO-1:0] exp_f;
    bit fe_seen = 0;
    for (int k = 0; k < NB; k++) b[k] = SIO'(k);
    exp_f = pack(b);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) begin
        checks++;
        if (output_valid !== 1'b0) begin
          failures++; $display("FAIL b2b_early_ov gaps=%0d: got %b want 0", gaps, output_valid);
        end
      end
      beat(b[k], k == 0);
      if (frame_error) fe_seen = 1;
      if (gaps && k != NB - 1) @(negedge clk);
    end
    checks++;
    if (output_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_ov gaps=%0d: got %b want 1", gaps, output_valid);
    end
    checks++;
    if (parallel_out !== exp_f) begin
      failures++; $display("FAIL b2b_data gaps=%0d: got %h want %h", gaps, parallel_out, exp_f);
    end
    checks++;
    if (fe_seen) begin
      failures++; $display("FAIL b2b_fe gaps=%0d: got 1 want 0", gaps);
    end
    release_frame();
  endtask

  task automatic test_hold_stall();
    logic [SIO-1:0] b [NB];
    logic [PIO-1:0] exp_f;
    int bad_ready = 0, bad_data = 0;
    for (int k = 0; k < NB; k++) b[k] = SIO'($urandom);
    exp_f = pack(b);
    for (int k = 0; k < NB; k++) beat(b[k], k == 0);
    output_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      serial_in = SIO'($urandom); input_valid = 1'b1; frame_start = c[0];
      @(negedge clk);
      if (input_ready !== 1'b0) bad_ready++;
      if (output_valid !== 1'b1 || parallel_out !== exp_f) bad_data++;
    end
    input_valid = 1'b0; frame_start = 1'b0;
    checks++;
    if (bad_ready != 0) begin
      failures++; $display("FAIL stall_ready: %0d cycles ready=1, want 0", bad_ready);
    end
    checks++;
    if (bad_data != 0) begin
      failures++; $display("FAIL stall_data: %0d cycles unstable, want 0", bad_data);
    end
    release_frame();
  endtask

  task automatic test_resync();
    logic [SIO-1:0] b [NB];
    logic [PIO-1:0] exp_f;
    for (int k = 0; k < 5; k++) beat(SIO'($urandom), k == 0);
    beat(16'hA5A5, 1'b1);
    checks++;
    if (frame_error !== 1'b1) begin
      failures++; $display("FAIL resync_fe_pulse: got %b want 1", frame_error);
    end
    b[0] = 16'hA5A5;
    for (int k = 1; k < NB; k++) begin
      b[k] = SIO'($urandom);
      beat(b[k], 1'b0);
      if (k == 1) begin
        checks++;
        if (frame_error !== 1'b0) begin
          failures++; $display("FAIL resync_fe_width: got %b want 0", frame_error);
        end
      end
    end
    exp_f = pack(b);
    checks++;
    if (output_valid !== 1'b1 || parallel_out[15:0] !== 16'hA5A5) begin
      failures++; $display("FAIL resync_beat0: ov=%b lsb=%h want 1 a5a5", output_valid, parallel_out[15:0]);
    end
    checks++;
    if (parallel_out !== exp_f) begin
      failures++; $display("FAIL resync_data: got %h want %h", parallel_out, exp_f);
    end
    release_frame();
  endtask

  task automatic test_reset_mid();
    logic [SIO-1:0] b [NB];
    logic [PIO-1:0] exp_f;
    int rises = 0;
    logic prev;
    for (int k = 0; k < 10; k++) beat(SIO'($urandom), k == 0);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++;
    if (output_valid !== 1'b0 || parallel_out !== '0) begin
      failures++; $display("FAIL midreset_clear: ov=%b data=%h want 0", output_valid, parallel_out);
    end
    prev = output_valid;
    for (int k = 0; k < NB; k++) begin
      b[k] = SIO'($urandom);
      beat(b[k], k == 0);
      if (output_valid && !prev) rises++;
      prev = output_valid;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (output_valid && !prev) rises++;
      prev = output_valid;
    end
    exp_f = pack(b);
    checks++;
    if (rises != 1) begin
      failures++; $display("FAIL midreset_ov_count: got %0d want 1", rises);
    end
    checks++;
    if (parallel_out !== exp_f) begin
      failures++; $display("FAIL midreset_data: got %h want %h", parallel_out, exp_f);
    end
    release_frame();
  endtask

  task automatic test_idle_ignore();
    int fe_cnt = 0, ov_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      beat(SIO'($urandom), 1'b0);
      if (frame_error) fe_cnt++;
      if (output_valid) ov_cnt++;
    end
    checks++;
    if (fe_cnt != 0) begin
      failures++; $display("FAIL idle_fe: got %0d pulses want 0", fe_cnt);
    end
    checks++;
    if (ov_cnt != 0) begin
      failures++; $display("FAIL idle_ov: got %0d cycles want 0", ov_cnt);
    end
  endtask

  // Reference: a frame is the NB beats following a frame_start; a new frame_start
  // while a frame is partially built is an error and restarts it.
  task automatic test_random();
    logic [SIO-1:0] cur [$];
    logic [SIO-1:0] b [NB];
    logic [PIO-1:0] exp_f;
    logic [SIO-1:0] d;
    logic v, s, exp_err, exp_done;
    int frames = 0;
    for (int step = 0; step < 1500; step++) begin
      if (output_valid) begin
        repeat ($urandom_range(0, 3)) begin
          input_valid = $urandom_range(0, 1); serial_in = SIO'($urandom);
          @(negedge clk);
          checks++;
          if (input_ready !== 1'b0) begin
            failures++; $display("FAIL rand_hold_ready step=%0d: got %b want 0", step, input_ready);
          end
        end
        input_valid = 1'b0;
        release_frame();
        continue;
      end
      v = ($urandom_range(0, 3) != 0);
      s = (cur.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      d = SIO'($urandom);
      exp_err = 1'b0; exp_done = 1'b0;
      if (v) begin
        if (s) begin
          if (cur.size() != 0) exp_err = 1'b1;
          cur.delete();
          cur.push_back(d);
        end else if (cur.size() != 0) begin
          cur.push_back(d);
        end
        if (cur.size() == NB) begin
          for (int k = 0; k < NB; k++) b[k] = cur[k];
          exp_f = pack(b);
          exp_done = 1'b1;
          cur.delete();
        end
      end
      serial_in = d; frame_start = s; input_valid = v;
      @(negedge clk);
      input_valid = 1'b0; frame_start = 1'b0;
      checks++;
      if (frame_error !== exp_err || output_valid !== exp_done) begin
        failures++;
        $display("FAIL rand_flags step=%0d: fe=%b ov=%b want %b %b", step, frame_error, output_valid, exp_err, exp_done);
      end
      if (exp_done) begin
        frames++;
        checks++;
        if (parallel_out !== exp_f) begin
          failures++; $display("FAIL rand_data step=%0d: got %h want %h", step, parallel_out, exp_f);
        end
      end
    end
    checks++;
    if (frames < 3) begin
      failures++; $display("FAIL rand_frames: got %0d frames want >=3", frames);
    end
  endtask

  initial begin
    reset = 1'b1; input_valid = 1'b0; frame_start = 1'b0; serial_in = '0; output_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_hold_stall();
    test_resync();
    test_reset_mid();
    test_idle_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
